// File: rtl/dot_product_arbiter.sv
// Round-robin arbiter sharing one dot-product engine among N requesters.
// Latency: ack one cycle after req seen in IDLE; resp_v 3 cycles + engine latency after req.
// Backpressure: requesters hold req until ack; engine handshake is eng_clr pulse / eng_out_v level.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req, req_a      per-requester request and packed D x W vectors
//   ack             one-cycle one-hot pulse when the winner's vector is captured
//   resp_v          one-cycle one-hot pulse, resp_data/resp_err valid with it
//   eng_clr, eng_a  clear pulse and operand vector to the shared engine
//   eng_out(_v)     engine result and its level-valid
// Optional: define ARB_TIMEOUT_EN to add a WAIT watchdog of TIMEOUT cycles
// that aborts the job with resp_data=0 and resp_err=1.

module dot_product_arbiter #(
  parameter int W       = 16,
  parameter int D       = 4,
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*D*W-1:0]   req_a,
  output logic [N-1:0]       ack,
  output logic [N-1:0]       resp_v,
  output logic [2*W-1:0]     resp_data,
  output logic               resp_err,
  output logic               eng_clr,
  output logic [D*W-1:0]     eng_a,
  input  logic [2*W-1:0]     eng_out,
  input  logic               eng_out_v
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_RESPOND} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;       // last granted index
  logic [IW-1:0]   winner;    // requester owning the job in flight
  logic            found;
  logic [IW-1:0]   win_idx;
  logic [IW:0]     cand;      // one extra bit so ptr+k cannot wrap before the mod-N fold
  logic [D*W-1:0]  sel_a;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   wd_cnt;
  logic            err_q;
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Scan starts one past the last grant, so the most recent winner is lowest priority.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  // Winner's vector via a constant-slice mux.
  always_comb begin
    sel_a = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == IW'(i)) sel_a = req_a[i*D*W +: D*W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= IW'(N-1);
      winner    <= '0;
      ack       <= '0;
      resp_v    <= '0;
      resp_data <= '0;
      eng_clr   <= 1'b0;
      eng_a     <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; each is raised for exactly one state.
      ack     <= '0;
      resp_v  <= '0;
      eng_clr <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (found) begin
            winner  <= win_idx;
            ack     <= onehot(win_idx);
            eng_clr <= 1'b1;
            eng_a   <= sel_a;   // held until the next grant
            state   <= S_GRANT;
          end
        end
        S_GRANT: begin
`ifdef ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_out_v) begin
            resp_data <= eng_out;
            resp_v    <= onehot(winner);
            state     <= S_RESPOND;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wd_cnt == CW'(TIMEOUT - 1)) begin
            resp_data <= '0;
            err_q     <= 1'b1;
            resp_v    <= onehot(winner);
            state     <= S_RESPOND;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
`endif
        end
        S_RESPOND: begin
          ptr   <= winner;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_arbiter.sv
module tb_dot_product_arbiter;

  localparam int W = 16, D = 4, N = 4, TO = 8;

  logic             clk, rst;
  logic [N-1:0]     req;
  logic [N*D*W-1:0] req_a;
  logic [N-1:0]     ack, resp_v;
  logic [2*W-1:0]   resp_data;
  logic             resp_err, eng_clr;
  logic [D*W-1:0]   eng_a;
  logic [2*W-1:0]   eng_out;
  logic             eng_out_v;

  dot_product_arbiter #(.W(W), .D(D), .N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .ack(ack), .resp_v(resp_v),
    .resp_data(resp_data), .resp_err(resp_err), .eng_clr(eng_clr), .eng_a(eng_a),
    .eng_out(eng_out), .eng_out_v(eng_out_v));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int viol   = 0;

  // Engine model with all weights 1: result = signed sum of elements.
  int eng_lat   = 0;
  bit eng_never = 0;
  int ecnt;

  function automatic logic [31:0] dot(input logic [63:0] a);
    int s;
    s = 0;
    for (int j = 0; j < 4; j++) s += int'($signed(a[j*16 +: 16]));
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_out_v <= 1'b0; eng_out <= '0; ecnt <= 0;
    end else if (eng_clr) begin
      eng_out_v <= 1'b0; ecnt <= 0;
    end else if (!eng_out_v && !eng_never) begin
      if (ecnt >= eng_lat) begin
        eng_out_v <= 1'b1;
        eng_out   <= dot(eng_a);
      end else begin
        ecnt <= ecnt + 1;
      end
    end
  end

  // Protocol monitor: ack/resp_v one-hot and never together.
  always @(negedge clk) begin
    if (!rst) begin
      if (ack != 0 && resp_v != 0) viol++;
      if ($countones(ack) > 1 || $countones(resp_v) > 1) viol++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Requester i gets element j = vec[j] + i, so a wrong winner changes the sum by 4 per index.
  task automatic load(input logic [63:0] vec);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < D; j++)
        req_a[(i*D + j)*W +: W] = vec[j*W +: W] + 16'(i);
  endtask

  task automatic scramble();
    for (int k = 0; k < N*D*W/32; k++) req_a[k*32 +: 32] = $urandom;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [63:0] vec;
    logic [3:0]  exp_ack;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n, acks, resps, bad_pulse, ng;
    logic [3:0] prev_ack;
    int order[5];
    int exp_order[5];
    logic clr_at_first;

    tbl[0] = '{4'b0001, {16'd4, 16'd3, 16'd2, 16'd1},                 4'b0001, 32'd10};
    tbl[1] = '{4'b0001, {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF},     4'b0001, 32'hFFFFFFF6};
    tbl[2] = '{4'b1010, {16'h0190, 16'h012C, 16'h00C8, 16'h0064},     4'b0010, 32'd1004};
    tbl[3] = '{4'b1010, {16'h0190, 16'h012C, 16'h00C8, 16'h0064},     4'b1000, 32'd1012};
    tbl[4] = '{4'b0110, {16'h8000, 16'h8000, 16'h8000, 16'h8000},     4'b0010, 32'hFFFE0004};
    tbl[5] = '{4'b1001, {16'h0000, 16'h0000, 16'h0000, 16'h0000},     4'b1000, 32'd12};
    tbl[6] = '{4'b1001, {16'hFFF9, 16'h0007, 16'hFFFB, 16'h0005},     4'b0001, 32'd0};
    tbl[7] = '{4'b0100, {16'h000A, 16'h07D0, 16'hF448, 16'h03E8},     4'b0100, 32'd18};
    exp_order = '{0, 1, 2, 3, 0};

    rst = 1'b1; req = '0; req_a = '0;
    step(); step();
    check("rst_ack", ack, 0);
    check("rst_resp_v", resp_v, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_eng_clr", eng_clr, 0);
    check("rst_eng_a", eng_a, 0);
    check("rst_resp_data", resp_data, 0);
    rst = 1'b0;
    step();

    // Table: one job per entry, round-robin pointer carries across entries.
    for (int t = 0; t < 8; t++) begin
      load(tbl[t].vec);
      req = tbl[t].req;
      step();
      check($sformatf("ack[%0d]", t), ack, tbl[t].exp_ack);
      check($sformatf("eng_clr[%0d]", t), eng_clr, 1);
      req = '0;
      scramble();   // eng_a must not follow req_a after capture
      n = 0;
      while (resp_v == 0 && n < 20) begin step(); n++; end
      check($sformatf("resp_lat[%0d]", t), n, 3);
      check($sformatf("resp_v[%0d]", t), resp_v, tbl[t].exp_ack);
      check($sformatf("resp_data[%0d]", t), resp_data, tbl[t].exp_data);
      check($sformatf("resp_err[%0d]", t), resp_err, 0);
      step();
    end

    // Withdrawal: req[2] pulsed during WAIT of a job for requester 0.
    eng_lat = 4;
    load(tbl[0].vec);
    req = 4'b0001;
    step();
    check("wd_ack0", ack, 4'b0001);
    req = '0;
    step(); step();
    req = 4'b0100;
    step();
    req = '0;
    acks = 0; resps = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (ack != 0) acks++;
      if (resp_v != 0) begin
        resps++;
        check("wd_resp_data", resp_data, 32'd10);
      end
    end
    check("wd_resp_count", resps, 1);
    check("wd_no_ack2", acks, 0);

    // Reset mid-WAIT with a stalled engine.
    eng_lat = 0; eng_never = 1;
    req = 4'b0001;
    step();
    req = '0;
    step(); step();
    rst = 1'b1;
    step();
    check("mid_rst_ack", ack, 0);
    check("mid_rst_eng_clr", eng_clr, 0);
    check("mid_rst_eng_a", eng_a, 0);
    check("mid_rst_resp_data", resp_data, 0);
    step();
    rst = 1'b0;
    eng_never = 0;
    resps = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (resp_v != 0 || ack != 0) resps++;
    end
    check("mid_rst_silent", resps, 0);

    // Fairness after reset: all requesting continuously.
    load(tbl[0].vec);
    req = 4'b1111;
    ng = 0; bad_pulse = 0; prev_ack = '0; clr_at_first = 1'b0;
    for (int c = 0; c < 60 && ng < 5; c++) begin
      step();
      if (ack != 0) begin
        if (prev_ack != 0) bad_pulse++;
        if (ng == 0) clr_at_first = eng_clr;
        for (int i = 0; i < N; i++) if (ack[i]) order[ng] = i;
        ng++;
      end
      prev_ack = ack;
    end
    req = '0;
    check("fair_grants", ng, 5);
    check("fair_first_clr", clr_at_first, 1);
    for (int k = 0; k < 5; k++) check($sformatf("fair_order[%0d]", k), order[k], exp_order[k]);
    check("fair_single_pulse", bad_pulse, 0);
    for (int c = 0; c < 8; c++) step();

`ifdef ARB_TIMEOUT_EN
    eng_never = 1;
    req = 4'b0001;
    step();
    req = '0;
    n = 0;
    while (resp_v == 0 && n < 30) begin step(); n++; end
    check("to_lat", n, TO + 1);
    check("to_resp_v", resp_v, 4'b0001);
    check("to_resp_err", resp_err, 1);
    check("to_resp_data", resp_data, 0);
    step();
    eng_never = 0;
`endif

    check("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
